sram_like_arbiter: RTL and testbench
====================================

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, the address width of all ports.
REQ-002 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 The block SHALL have ports i_req/i_wr/i_size/i_addr/i_wdata, inputs, 1/1/2/ADDR_W/32, the instruction-master request.
REQ-005 The block SHALL have ports i_rdata/i_addr_ok/i_data_ok, outputs, 32/1/1, the instruction-master response.
REQ-006 The block SHALL have ports d_req/d_wr/d_size/d_addr/d_wdata, inputs, 1/1/2/ADDR_W/32, the data-master request.
REQ-007 The block SHALL have ports d_rdata/d_addr_ok/d_data_ok, outputs, 32/1/1, the data-master response.
REQ-008 The block SHALL have ports s_req/s_wr/s_size/s_addr/s_wdata, outputs, 1/1/2/ADDR_W/32, the shared slave request.
REQ-009 The block SHALL have ports s_rdata/s_addr_ok/s_data_ok, inputs, 32/1/1, the shared slave response.

Function
REQ-010 The block SHALL implement a state machine with states IDLE, WAIT_ADDR and WAIT_DATA, and a registered owner (INST/DATA).
REQ-011 In IDLE the block SHALL pick a winner combinationally among asserted i_req/d_req and forward the winner's request fields to s_* in the same cycle (zero-cycle request latency).
REQ-012 Default priority SHALL be fixed, with data over instruction.
REQ-013 In IDLE with a winner: s_addr_ok=1 SHALL latch owner and go to WAIT_DATA; s_addr_ok=0 SHALL latch owner and go to WAIT_ADDR.
REQ-014 In WAIT_ADDR the owner's fields SHALL be forwarded regardless of the other master's req; s_addr_ok=1 SHALL go to WAIT_DATA.
REQ-015 In WAIT_ADDR, owner req deasserting (e.g. data-side flush) without s_addr_ok SHALL return to IDLE with s_req=0 that cycle.
REQ-016 In WAIT_DATA, s_req SHALL be 0; s_data_ok=1 SHALL route s_rdata and a one-cycle data_ok to the owner only, then go to IDLE.
REQ-017 s_addr_ok SHALL be routed only to the current winner/owner; the non-owner's addr_ok, data_ok and rdata SHALL be 0.
REQ-018 At most one transaction SHALL be outstanding; a new request SHALL not be forwarded in the cycle s_data_ok is seen (next grant earliest the following cycle).
REQ-019 With no request in IDLE, all s_* outputs SHALL be 0.
REQ-020 s_data_ok received in IDLE or WAIT_ADDR SHALL be ignored (not routed).

Reset
REQ-021 rst SHALL force IDLE, owner=INST, round-robin pointer=INST, and all outputs to 0 on the next edge, including mid-transaction; the aborted transaction's data_ok SHALL not be delivered.

Configuration
REQ-022 With macro SRAM_ARB_ROUND_ROBIN_EN defined, priority SHALL alternate: the master not granted last wins a tie, and the pointer SHALL update on each s_addr_ok.
REQ-023 Without SRAM_ARB_ROUND_ROBIN_EN, fixed data-over-instruction priority (REQ-012) SHALL apply and no pointer register SHALL exist.

Structure
REQ-024 State encoding and owner constants (OWN_INST=0, OWN_DATA=1) SHALL live in shared package sram_arb_pkg.
REQ-025 The winner selection SHALL be a sub-module sram_arb_pick (inputs i_req, d_req, pointer; output grant).

Verification
REQ-026 i_req=1 alone, addr 0x1FC00000, s_addr_ok same cycle, s_data_ok 2 cycles later with 0x3C1D0000 -> i_addr_ok=1 that cycle, i_data_ok=1 with i_rdata=0x3C1D0000, d_* responses 0.
REQ-027 i_req and d_req both 1 (d_addr 0x00001000, d_wr=1, size 2'b10) in IDLE -> s_addr=0x00001000, s_wr=1; instruction granted only after d_data_ok.
REQ-028 d_req=1, s_addr_ok held 0 for 3 cycles, then i_req rises -> s_addr stays at d_addr until s_addr_ok; no i_addr_ok.
REQ-029 d_req drops in WAIT_ADDR without s_addr_ok -> IDLE next cycle, s_req=0; pending i_req granted the cycle after.
REQ-030 With SRAM_ARB_ROUND_ROBIN_EN, both masters requesting continuously for 4 transactions -> grant order DATA, INST, DATA, INST.
REQ-031 rst asserted in WAIT_DATA, s_data_ok arrives the cycle after -> all outputs 0, no data_ok to either master.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared state encoding and owner constants for the SRAM-like arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    function automatic logic other_master(input logic own);
        return ~own;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Winner selection between the instruction and data masters.
// pointer names the master granted last; on a tie the other one wins.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic pointer,
    output logic grant_vld,
    output logic grant
);

    always_comb begin
        grant_vld = i_req | d_req;
        grant     = OWN_INST;
        if (i_req && d_req) begin
            grant = other_master(pointer);
        end else if (d_req) begin
            grant = OWN_DATA;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like arbiter, one transaction outstanding.
// Define SRAM_ARB_ROUND_ROBIN_EN for alternating tie priority; default is data over inst.
//   state      | meaning
//   IDLE       | no owner, combinational pick forwarded to slave
//   WAIT_ADDR  | owner's request presented, waiting for s_addr_ok
//   WAIT_DATA  | address accepted, waiting for s_data_ok
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       i_rdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,

    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [ADDR_W-1:0] s_addr,
    output logic [31:0]       s_wdata,
    input  logic [31:0]       s_rdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok
);

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_own;
    logic   grant_vld, grant;
    logic   fwd_vld, fwd_own, addr_acc;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;
    assign last_own = ptr_q;
`else
    // Pretending inst was granted last makes every tie go to data.
    assign last_own = OWN_INST;
`endif

    sram_arb_pick u_pick (
        .i_req     (i_req),
        .d_req     (d_req),
        .pointer   (last_own),
        .grant_vld (grant_vld),
        .grant     (grant)
    );

    // Which master (if any) is presented to the slave this cycle.
    always_comb begin
        fwd_vld = 1'b0;
        fwd_own = owner_q;
        case (state_q)
            ST_IDLE: begin
                fwd_vld = grant_vld;
                fwd_own = grant;
            end
            ST_WAIT_ADDR: begin
                fwd_vld = (owner_q == OWN_DATA) ? d_req : i_req;
            end
            default: ;
        endcase
        if (rst) begin
            fwd_vld = 1'b0;
        end
    end

    assign addr_acc = fwd_vld & s_addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_INST;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= OWN_INST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (addr_acc) begin
            ptr_d = fwd_own;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    owner_d = grant;
                    state_d = s_addr_ok ? ST_WAIT_DATA : ST_WAIT_ADDR;
                end
            end
            ST_WAIT_ADDR: begin
                // Owner withdrawing its request (e.g. flush) abandons the handshake.
                if (!fwd_vld) begin
                    state_d = ST_IDLE;
                end else if (s_addr_ok) begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (s_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        s_req     = 1'b0;
        s_wr      = 1'b0;
        s_size    = '0;
        s_addr    = '0;
        s_wdata   = '0;
        i_addr_ok = 1'b0;
        d_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_data_ok = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;

        if (fwd_vld) begin
            s_req = 1'b1;
            if (fwd_own == OWN_DATA) begin
                s_wr    = d_wr;
                s_size  = d_size;
                s_addr  = d_addr;
                s_wdata = d_wdata;
            end else begin
                s_wr    = i_wr;
                s_size  = i_size;
                s_addr  = i_addr;
                s_wdata = i_wdata;
            end
        end

        i_addr_ok = addr_acc & (fwd_own == OWN_INST);
        d_addr_ok = addr_acc & (fwd_own == OWN_DATA);

        if ((state_q == ST_WAIT_DATA) && s_data_ok && !rst) begin
            if (owner_q == OWN_DATA) begin
                d_data_ok = 1'b1;
                d_rdata   = s_rdata;
            end else begin
                i_data_ok = 1'b1;
                i_rdata   = s_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_sram_like_arbiter;

    localparam bit INST = 1'b0;
    localparam bit DATA = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [31:0] i_rdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        s_addr_ok, s_data_ok;

    int checks = 0;
    int errors = 0;

    logic [67:0] obs_s, obs_r;
    assign obs_s = {s_req, s_wr, s_size, s_addr, s_wdata};
    assign obs_r = {i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata};

    always #5 clk = ~clk;

    sram_like_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok)
    );

    function automatic logic [67:0] mk_s(input logic req, input logic wr, input logic [1:0] size,
                                         input logic [31:0] addr, input logic [31:0] wdata);
        return {req, wr, size, addr, wdata};
    endfunction

    function automatic logic [67:0] mk_r(input logic iaok, input logic idok, input logic [31:0] ird,
                                         input logic daok, input logic ddok, input logic [31:0] drd);
        return {iaok, idok, ird, daok, ddok, drd};
    endfunction

    task automatic drive_idle();
        i_req = 1'b0; i_wr = 1'b0; i_size = 2'b00; i_addr = '0; i_wdata = '0;
        d_req = 1'b0; d_wr = 1'b0; d_size = 2'b00; d_addr = '0; d_wdata = '0;
        s_rdata = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (obs_s !== '0) begin
            errors++; $display("FAIL reset_sbus: got %h expected 0", obs_s);
        end
        checks++;
        if (obs_r !== '0) begin
            errors++; $display("FAIL reset_resp: got %h expected 0", obs_r);
        end
        tick();
        drive_idle(); rst = 1'b0;
        #1;
        checks++;
        if (obs_s !== '0) begin
            errors++; $display("FAIL idle_sbus: got %h expected 0", obs_s);
        end
        checks++;
        if (obs_r !== '0) begin
            errors++; $display("FAIL idle_resp: got %h expected 0", obs_r);
        end
    endtask

    task automatic test_inst_fetch();
        tick();
        i_req = 1'b1; i_size = 2'b10; i_addr = 32'h1FC0_0000; s_addr_ok = 1'b1;
        #1;
        checks++;
        if (obs_s !== mk_s(1'b1, 1'b0, 2'b10, 32'h1FC0_0000, '0)) begin
            errors++; $display("FAIL fetch_fwd: got %h expected %h", obs_s, mk_s(1'b1, 1'b0, 2'b10, 32'h1FC0_0000, '0));
        end
        checks++;
        if (obs_r !== mk_r(1'b1, 1'b0, '0, 1'b0, 1'b0, '0)) begin
            errors++; $display("FAIL fetch_addr_ok: got %h", obs_r);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if ({obs_s, obs_r} !== '0) begin
            errors++; $display("FAIL fetch_wait: got %h %h expected 0", obs_s, obs_r);
        end
        tick();
        s_data_ok = 1'b1; s_rdata = 32'h3C1D_0000;
        #1;
        checks++;
        if (obs_r !== mk_r(1'b0, 1'b1, 32'h3C1D_0000, 1'b0, 1'b0, '0)) begin
            errors++; $display("FAIL fetch_data_ok: got %h", obs_r);
        end
        tick();
        drive_idle();
        #1;
        checks++;
        if (obs_r !== '0) begin
            errors++; $display("FAIL fetch_one_shot: got %h expected 0", obs_r);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] w, r;
        w = $urandom; r = $urandom;
        tick();
        i_req = 1'b1; i_size = 2'b10; i_addr = 32'h1FC0_0004;
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'b10; d_addr = 32'h0000_1000; d_wdata = w;
        s_addr_ok = 1'b1;
        #1;
        checks++;
        if (obs_s !== mk_s(1'b1, 1'b1, 2'b10, 32'h0000_1000, w)) begin
            errors++; $display("FAIL conflict_fwd: got %h expected %h", obs_s, mk_s(1'b1, 1'b1, 2'b10, 32'h0000_1000, w));
        end
        checks++;
        if (obs_r !== mk_r(1'b0, 1'b0, '0, 1'b1, 1'b0, '0)) begin
            errors++; $display("FAIL conflict_aok: got %h", obs_r);
        end
        tick();
        d_req = 1'b0;
        #1;
        checks++;
        if ({obs_s, obs_r} !== '0) begin
            errors++; $display("FAIL conflict_wait: got %h %h expected 0", obs_s, obs_r);
        end
        tick();
        s_data_ok = 1'b1; s_rdata = r;
        #1;
        checks++;
        if (obs_r !== mk_r(1'b0, 1'b0, '0, 1'b0, 1'b1, r) || obs_s !== '0) begin
            errors++; $display("FAIL conflict_dok: got %h %h", obs_r, obs_s);
        end
        tick();
        s_data_ok = 1'b0;
        #1;
        checks++;
        if (obs_s !== mk_s(1'b1, 1'b0, 2'b10, 32'h1FC0_0004, '0) || obs_r !== mk_r(1'b1, 1'b0, '0, 1'b0, 1'b0, '0)) begin
            errors++; $display("FAIL conflict_inst_grant: got %h %h", obs_s, obs_r);
        end
        tick();
        i_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = ~r;
        #1;
        checks++;
        if (obs_r !== mk_r(1'b0, 1'b1, ~r, 1'b0, 1'b0, '0)) begin
            errors++; $display("FAIL conflict_inst_dok: got %h", obs_r);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_addr_stall();
        logic [31:0] a, w, r;
        a = $urandom; w = $urandom; r = $urandom;
        for (int k = 0; k < 5; k++) begin
            tick();
            d_req = 1'b1; d_size = 2'b01; d_addr = a; d_wdata = w; s_addr_ok = 1'b0;
            if (k >= 3) begin
                i_req = 1'b1; i_addr = ~a; i_wdata = ~w;
            end
            #1;
            checks++;
            if (obs_s !== mk_s(1'b1, 1'b0, 2'b01, a, w) || obs_r !== '0) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h %h", k, obs_s, obs_r);
            end
        end
        tick();
        s_addr_ok = 1'b1;
        #1;
        checks++;
        if (obs_s !== mk_s(1'b1, 1'b0, 2'b01, a, w) || obs_r !== mk_r(1'b0, 1'b0, '0, 1'b1, 1'b0, '0)) begin
            errors++; $display("FAIL stall_accept: got %h %h", obs_s, obs_r);
        end
        tick();
        drive_idle(); s_data_ok = 1'b1; s_rdata = r;
        #1;
        checks++;
        if (obs_r !== mk_r(1'b0, 1'b0, '0, 1'b0, 1'b1, r)) begin
            errors++; $display("FAIL stall_dok: got %h", obs_r);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_flush();
        logic [31:0] a, b, r;
        a = $urandom; b = $urandom; r = $urandom;
        tick();
        d_req = 1'b1; d_addr = a;
        #1;
        checks++;
        if (obs_s !== mk_s(1'b1, 1'b0, 2'b00, a, '0)) begin
            errors++; $display("FAIL flush_fwd: got %h", obs_s);
        end
        tick();
        d_req = 1'b0; i_req = 1'b1; i_addr = b; i_size = 2'b10;
        #1;
        checks++;
        if ({obs_s, obs_r} !== '0) begin
            errors++; $display("FAIL flush_drop: got %h %h expected 0", obs_s, obs_r);
        end
        tick();
        s_addr_ok = 1'b1;
        #1;
        checks++;
        if (obs_s !== mk_s(1'b1, 1'b0, 2'b10, b, '0) || obs_r !== mk_r(1'b1, 1'b0, '0, 1'b0, 1'b0, '0)) begin
            errors++; $display("FAIL flush_inst_grant: got %h %h", obs_s, obs_r);
        end
        tick();
        drive_idle(); s_data_ok = 1'b1; s_rdata = r;
        #1;
        checks++;
        if (obs_r !== mk_r(1'b0, 1'b1, r, 1'b0, 1'b0, '0)) begin
            errors++; $display("FAIL flush_dok: got %h", obs_r);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_priority_order();
        bit exp_own;
        logic [31:0] ia, da;
        ia = 32'hBFC0_0100; da = 32'h8000_2000;
        for (int t = 0; t < 4; t++) begin
            // Last grant before this test was INST, so a rotating scheme starts with DATA.
            exp_own = RR ? ((t % 2 == 0) ? DATA : INST) : DATA;
            tick();
            i_req = 1'b1; i_addr = ia; d_req = 1'b1; d_addr = da;
            s_data_ok = 1'b0; s_addr_ok = 1'b1;
            #1;
            checks++;
            if (obs_s !== mk_s(1'b1, 1'b0, 2'b00, exp_own ? da : ia, '0)
                || obs_r !== mk_r(!exp_own, 1'b0, '0, exp_own, 1'b0, '0)) begin
                errors++; $display("FAIL order_grant[%0d]: got %h %h expected owner %0d", t, obs_s, obs_r, exp_own);
            end
            tick();
            s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'(t + 100);
            #1;
            checks++;
            if (obs_r !== mk_r(1'b0, !exp_own, exp_own ? '0 : 32'(t + 100), 1'b0, exp_own, exp_own ? 32'(t + 100) : '0)
                || s_req !== 1'b0) begin
                errors++; $display("FAIL order_dok[%0d]: got %h s_req %b", t, obs_r, s_req);
            end
        end
        tick();
        drive_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        r = $urandom;
        tick();
        i_req = 1'b1; i_addr = 32'h1FC0_0040; s_addr_ok = 1'b1;
        #1;
        checks++;
        if (obs_r !== mk_r(1'b1, 1'b0, '0, 1'b0, 1'b0, '0)) begin
            errors++; $display("FAIL rmid_aok: got %h", obs_r);
        end
        tick();
        drive_idle(); rst = 1'b1;
        #1;
        checks++;
        if ({obs_s, obs_r} !== '0) begin
            errors++; $display("FAIL rmid_in_reset: got %h %h expected 0", obs_s, obs_r);
        end
        tick();
        rst = 1'b0; s_data_ok = 1'b1; s_rdata = r;
        #1;
        checks++;
        if ({obs_s, obs_r} !== '0) begin
            errors++; $display("FAIL rmid_no_dok: got %h %h expected 0", obs_s, obs_r);
        end
        tick();
        s_data_ok = 1'b0; i_req = 1'b1; d_req = 1'b1; d_addr = 32'h40; s_addr_ok = 1'b1;
        #1;
        checks++;
        if (obs_r !== mk_r(1'b0, 1'b0, '0, 1'b1, 1'b0, '0)) begin
            errors++; $display("FAIL rmid_regrant: got %h", obs_r);
        end
        tick();
        drive_idle(); s_data_ok = 1'b1; s_rdata = r;
        #1;
        checks++;
        if (obs_r !== mk_r(1'b0, 1'b0, '0, 1'b0, 1'b1, r)) begin
            errors++; $display("FAIL rmid_regrant_dok: got %h", obs_r);
        end
        tick();
        drive_idle();
    endtask

    task automatic test_random();
        // Model: one accepted transaction (busy) or one presented-but-unaccepted request (pend).
        bit m_busy, m_busy_who, m_pend, m_pend_who, m_last;
        bit present, who;
        logic [67:0] e_s, e_r;
        m_busy = 1'b0; m_busy_who = INST; m_pend = 1'b0; m_pend_who = INST; m_last = INST;
        for (int n = 0; n < 800; n++) begin
            tick();
            rst       = (n == 0) || ($urandom_range(0, 59) == 0);
            i_req     = ($urandom_range(0, 99) < 55);
            d_req     = ($urandom_range(0, 99) < 55);
            i_wr      = 1'($urandom); d_wr = 1'($urandom);
            i_size    = 2'($urandom); d_size = 2'($urandom);
            i_addr    = $urandom; d_addr = $urandom;
            i_wdata   = $urandom; d_wdata = $urandom;
            s_rdata   = $urandom;
            s_addr_ok = ($urandom_range(0, 99) < 50);
            s_data_ok = ($urandom_range(0, 99) < 40);
            #1;
            e_s = '0; e_r = '0;
            if (rst) begin
                m_busy = 1'b0; m_pend = 1'b0; m_last = INST;
            end else if (m_busy) begin
                if (s_data_ok) begin
                    e_r = (m_busy_who == DATA) ? mk_r(1'b0, 1'b0, '0, 1'b0, 1'b1, s_rdata)
                                               : mk_r(1'b0, 1'b1, s_rdata, 1'b0, 1'b0, '0);
                    m_busy = 1'b0;
                end
            end else begin
                present = 1'b0; who = INST;
                if (m_pend) begin
                    who = m_pend_who;
                    present = (who == DATA) ? d_req : i_req;
                    if (!present) m_pend = 1'b0;
                end else if (i_req || d_req) begin
                    present = 1'b1;
                    if (i_req && d_req) who = RR ? !m_last : DATA;
                    else                who = d_req;
                end
                if (present) begin
                    e_s = (who == DATA) ? mk_s(1'b1, d_wr, d_size, d_addr, d_wdata)
                                        : mk_s(1'b1, i_wr, i_size, i_addr, i_wdata);
                    if (s_addr_ok) begin
                        e_r = (who == DATA) ? mk_r(1'b0, 1'b0, '0, 1'b1, 1'b0, '0)
                                            : mk_r(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
                        m_busy = 1'b1; m_busy_who = who; m_pend = 1'b0; m_last = who;
                    end else begin
                        m_pend = 1'b1; m_pend_who = who;
                    end
                end
            end
            checks++;
            if (obs_s !== e_s) begin
                errors++; $display("FAIL rand_sbus[%0d]: got %h expected %h", n, obs_s, e_s);
            end
            checks++;
            if (obs_r !== e_r) begin
                errors++; $display("FAIL rand_resp[%0d]: got %h expected %h", n, obs_r, e_r);
            end
        end
        tick();
        drive_idle(); rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_inst_fetch();
        test_conflict();
        test_addr_stall();
        test_flush();
        test_priority_order();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
